run_step_controller: RTL and testbench

RUN_STEP_CONTROLLER -- requirements
Module: run_step_controller

---
 rtl/run_step_controller_pkg.sv | 28 ++
 rtl/run_step_controller_key_debouncer.sv | 51 +++++
 rtl/run_step_controller.sv | 158 +++++++++++++++
 tb/tb_run_step_controller.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_step_controller_pkg.sv
// Shared constants for the run/step controller: FSM state encoding,
// key and switch bit positions, and the clock-divide mask helper.
package run_step_controller_pkg;

    typedef enum logic [1:0] {
        ST_RESET_HOLD = 2'd0,
        ST_HALT       = 2'd1,
        ST_STEP       = 2'd2,
        ST_RUN        = 2'd3
    } state_t;

    // Key bit positions (key port is numbered [3:1] to match the board KEY names)
    localparam int KEY_STEP       = 1;
    localparam int KEY_PAUSE      = 2;
    localparam int KEY_CORE_RESET = 3;

    // Switch bit positions
    localparam int SW_RUN     = 0;
    localparam int SW_DIV_EN  = 1;
    localparam int SW_EXP_LSB = 4;
    localparam int SW_EXP_MSB = 7;

    // Mask of the low E prescaler bits; zero under the mask marks a divided tick
    function automatic logic [15:0] div_mask(input logic [3:0] exponent);
        return (16'd1 << exponent) - 16'd1;
    endfunction

endpackage

// File: rtl/run_step_controller_key_debouncer.sv
// One push-button channel: 2-flop synchronizer, level debounce and a
// single-cycle press pulse on the accepted released->pressed transition.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_key,
    output logic o_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    r_sync;
    logic          r_level;
    logic [CW-1:0] r_count;
    logic          r_press;
    logic          w_sample;

    assign w_sample = r_sync[1];
    assign o_press  = r_press;

    // Synchronize the raw key; resets to released so reset release never looks like a press
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_key};
        end
    end

    // Count consecutive samples that disagree with the accepted level; accept after enough of them
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_level <= 1'b1;
            r_count <= '0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (w_sample == r_level) begin
                r_count <= '0;
            end else if (r_count == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_level <= w_sample;
                r_count <= '0;
                r_press <= ~w_sample;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/run_step_controller.sv
// Run/step/pause controller for a single-clock core: generates a registered
// clock-enable qualifier, a held core reset and a count of enable pulses.
module run_step_controller
    import run_step_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int RESET_HOLD_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:1]  key,
    input  logic [7:0]  switch,
    output logic        core_clock_enable,
    output logic        core_reset,
    output logic        running,
    output logic [31:0] enable_count
);
    localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);

    logic [7:0]    r_sw_meta;
    logic [7:0]    r_sw_sync;
    logic [3:1]    w_press;

    state_t        r_state;
    logic [HW-1:0] r_hold_count;
    logic [15:0]   r_prescaler;
    logic          r_pause;
    logic          r_core_reset;
    logic          r_clock_enable;
    logic          r_running;
    logic [31:0]   r_enable_count;

    logic          w_run_on;
    logic          w_div_on;
    logic [15:0]   w_mask;
    logic [15:0]   w_prescaler_inc;
    logic          w_run_tick;
    logic          w_pause_after;
    logic          w_unused_sw;

    // Two-flop synchronizer for the slide switches
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= switch;
            r_sw_sync <= r_sw_meta;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi <= 3; gi++) begin : g_key
            key_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_key_debouncer (
                .i_clock   (clock),
                .i_reset_n (reset_n),
                .i_key     (key[gi]),
                .o_press   (w_press[gi])
            );
        end
    endgenerate

    assign w_run_on        = r_sw_sync[SW_RUN];
    assign w_div_on        = r_sw_sync[SW_DIV_EN];
    assign w_mask          = div_mask(r_sw_sync[SW_EXP_MSB:SW_EXP_LSB]);
    assign w_prescaler_inc = r_prescaler + 16'd1;
    assign w_run_tick      = !w_div_on || ((w_prescaler_inc & w_mask) == 16'd0);
    // Decisions in a cycle with a pause press use the already-toggled flag
    assign w_pause_after   = r_pause ^ w_press[KEY_PAUSE];
    assign w_unused_sw     = ^r_sw_sync[3:2];

    // Controller FSM; outputs are registered alongside the state they describe
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_RESET_HOLD;
            r_hold_count   <= '0;
            r_prescaler    <= '0;
            r_pause        <= 1'b0;
            r_core_reset   <= 1'b1;
            r_clock_enable <= 1'b0;
            r_running      <= 1'b0;
            r_enable_count <= '0;
        end else begin
            r_clock_enable <= 1'b0;
            if (w_press[KEY_CORE_RESET]) begin
                // Core reset wins over step/pause and restarts any hold in progress
                r_state        <= ST_RESET_HOLD;
                r_hold_count   <= '0;
                r_core_reset   <= 1'b1;
                r_running      <= 1'b0;
                r_enable_count <= '0;
            end else begin
                case (r_state)
                    ST_RESET_HOLD: begin
                        r_enable_count <= '0;
                        if (r_hold_count == HW'(RESET_HOLD_CYCLES - 1)) begin
                            r_hold_count <= '0;
                            r_core_reset <= 1'b0;
                            if (w_run_on && !r_pause) begin
                                r_state        <= ST_RUN;
                                r_running      <= 1'b1;
                                r_prescaler    <= '0;
                                r_clock_enable <= 1'b1;
                                r_enable_count <= 32'd1;
                            end else begin
                                r_state <= ST_HALT;
                            end
                        end else begin
                            r_hold_count <= r_hold_count + 1'b1;
                        end
                    end
                    ST_HALT: begin
                        r_pause <= w_pause_after;
                        if (w_press[KEY_STEP]) begin
                            r_state        <= ST_STEP;
                            r_clock_enable <= 1'b1;
                            r_enable_count <= r_enable_count + 32'd1;
                        end else if (w_run_on && !w_pause_after) begin
                            // First RUN cycle has prescaler 0 and therefore always enables
                            r_state        <= ST_RUN;
                            r_running      <= 1'b1;
                            r_prescaler    <= '0;
                            r_clock_enable <= 1'b1;
                            r_enable_count <= r_enable_count + 32'd1;
                        end
                    end
                    ST_STEP: begin
                        r_pause <= w_pause_after;
                        r_state <= ST_HALT;
                    end
                    ST_RUN: begin
                        r_pause <= w_pause_after;
                        if (!w_run_on || w_pause_after) begin
                            r_state   <= ST_HALT;
                            r_running <= 1'b0;
                        end else begin
                            r_prescaler    <= w_prescaler_inc;
                            r_clock_enable <= w_run_tick;
                            r_enable_count <= r_enable_count + {31'd0, w_run_tick};
                        end
                    end
                    default: begin
                        r_state <= ST_RESET_HOLD;
                    end
                endcase
            end
        end
    end

    assign core_clock_enable = r_clock_enable;
    assign core_reset        = r_core_reset;
    assign running           = r_running;
    assign enable_count      = r_enable_count;

endmodule

// File: tb/tb_run_step_controller.sv
// Randomized scoreboard bench for run_step_controller with a behavioural
// reference model driven from the same raw key/switch inputs.
module tb_run_step_controller;

    localparam int DEB  = 4;
    localparam int HOLD = 16;

    localparam int M_HOLD = 0;
    localparam int M_HALT = 1;
    localparam int M_STEP = 2;
    localparam int M_RUN  = 3;

    typedef struct packed {
        logic        cr;
        logic        ce;
        logic        run;
        logic [31:0] cnt;
    } exp_t;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:1]  key     = 3'b111;
    logic [7:0]  switch  = 8'h00;
    logic        core_clock_enable;
    logic        core_reset;
    logic        running;
    logic [31:0] enable_count;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    exp_t exp_q[$];

    // Reference model state
    logic [3:1]  m_key1, m_key2, m_lvl, m_press;
    logic [7:0]  m_sw1, m_sw2;
    logic [3:1]  samp_q[$];
    int          m_mode;
    int          m_hold_left;
    logic        m_pause;
    int unsigned m_run_cycles;
    logic        m_ce;
    logic [31:0] m_cnt;

    run_step_controller #(
        .DEBOUNCE_CYCLES   (DEB),
        .RESET_HOLD_CYCLES (HOLD)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .key               (key),
        .switch            (switch),
        .core_clock_enable (core_clock_enable),
        .core_reset        (core_reset),
        .running           (running),
        .enable_count      (enable_count)
    );

    initial forever #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic m_reset();
        m_key1 = 3'b111; m_key2 = 3'b111; m_lvl = 3'b111; m_press = 3'b000;
        m_sw1 = 8'h00; m_sw2 = 8'h00;
        samp_q.delete();
        for (int i = 0; i < DEB; i++) samp_q.push_back(3'b111);
        m_mode = M_HOLD; m_hold_left = HOLD; m_pause = 1'b0;
        m_run_cycles = 0; m_ce = 1'b0; m_cnt = 32'd0;
    endtask

    task automatic m_enter_run();
        m_mode = M_RUN; m_run_cycles = 0; m_ce = 1'b1; m_cnt = m_cnt + 32'd1;
    endtask

    task automatic m_step();
        logic [3:1] p;
        logic [3:1] np;
        logic       run_on;
        logic       all_diff;
        int unsigned period;
        p      = m_press;
        run_on = m_sw2[0];
        m_ce   = 1'b0;
        if (p[3]) begin
            m_mode = M_HOLD; m_hold_left = HOLD; m_cnt = 32'd0;
        end else begin
            case (m_mode)
                M_HOLD: begin
                    m_hold_left--;
                    if (m_hold_left == 0) begin
                        if (run_on && !m_pause) m_enter_run();
                        else m_mode = M_HALT;
                    end
                end
                M_HALT: begin
                    if (p[2]) m_pause = !m_pause;
                    if (p[1]) begin
                        m_mode = M_STEP; m_ce = 1'b1; m_cnt = m_cnt + 32'd1;
                    end else if (run_on && !m_pause) begin
                        m_enter_run();
                    end
                end
                M_STEP: begin
                    if (p[2]) m_pause = !m_pause;
                    m_mode = M_HALT;
                end
                default: begin
                    if (p[2]) m_pause = !m_pause;
                    if (!run_on || m_pause) begin
                        m_mode = M_HALT;
                    end else begin
                        m_run_cycles++;
                        period = 32'd1 << m_sw2[7:4];
                        m_ce = !m_sw2[1] || ((m_run_cycles % period) == 0);
                        if (m_ce) m_cnt = m_cnt + 32'd1;
                    end
                end
            endcase
        end
        // Debounce: a key level flips once the last DEB samples all disagree with it
        samp_q.push_back(m_key2);
        void'(samp_q.pop_front());
        np = 3'b000;
        for (int b = 1; b <= 3; b++) begin
            all_diff = 1'b1;
            for (int i = 0; i < samp_q.size(); i++)
                if (samp_q[i][b] == m_lvl[b]) all_diff = 1'b0;
            if (all_diff) begin
                m_lvl[b] = ~m_lvl[b];
                if (!m_lvl[b]) np[b] = 1'b1;
            end
        end
        m_press = np;
        m_key2 = m_key1; m_key1 = key;
        m_sw2  = m_sw1;  m_sw1  = switch;
    endtask

    // Model: one expected output record per clock (or per asynchronous reset)
    initial begin
        m_reset();
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                m_reset();
                exp_q.delete();
            end else begin
                m_step();
            end
            exp_q.push_back({(m_mode == M_HOLD), m_ce, (m_mode == M_RUN), m_cnt});
        end
    end

    // Monitor: pop and compare the DUT outputs once per cycle
    initial forever begin
        exp_t e;
        exp_t got;
        @(negedge clock);
        got = {core_reset, core_clock_enable, running, enable_count};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_underflow: got empty queue, expected one record");
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL outputs @%0t: got cr=%b ce=%b run=%b cnt=%0d, expected cr=%b ce=%b run=%b cnt=%0d",
                         $time, got.cr, got.ce, got.run, got.cnt, e.cr, e.ce, e.run, e.cnt);
            end else if (e.ce) begin
                txn++;
                $display("txn %0d: enable pulse, enable_count=%0d", txn, e.cnt);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input logic [3:1] low_mask, input int n);
        key = ~low_mask;
        cycles(n);
        key = 3'b111;
    endtask

    task automatic count_reset_hold(input string name);
        int n;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (core_reset) n++;
            else break;
        end
        check(name, n, HOLD);
    endtask

    initial begin
        logic [3:1] k;
        logic [7:0] sw;
        int r;

        // Release just after an edge so the hold count starts from a full cycle
        cycles(3);
        @(posedge clock);
        #1 reset_n = 1'b1;
        count_reset_hold("reset_hold_len");
        cycles(5);
        check("halt_no_enable_count", enable_count, 0);
        check("halt_running", {31'd0, running}, 0);

        // Single step, then a glitch that must be rejected
        press(3'b001, 10);
        cycles(20);
        check("step_count", enable_count, 1);
        press(3'b001, 3);
        cycles(20);
        check("glitch_count", enable_count, 1);

        // RUN undivided, then divided by 8 from a fresh entry
        switch = 8'h03;
        cycles(40);
        switch = 8'h32;
        cycles(10);
        switch = 8'h33;
        cycles(60);

        // Pause and resume
        press(3'b010, 10);
        cycles(20);
        check("paused_running", {31'd0, running}, 0);
        press(3'b010, 10);
        cycles(20);
        check("resumed_running", {31'd0, running}, 1);

        // Core reset together with step
        press(3'b101, 10);
        cycles(40);

        // Asynchronous reset pulse mid-RUN, between clock edges
        switch = 8'h03;
        cycles(30);
        @(posedge clock);
        #1 reset_n = 1'b0;
        #2;
        check("async_ce_drop", {31'd0, core_clock_enable}, 0);
        check("async_running_drop", {31'd0, running}, 0);
        check("async_count_clear", enable_count, 0);
        #1 reset_n = 1'b1;
        count_reset_hold("async_reset_hold_len");
        cycles(30);

        // Randomized key/switch activity
        for (int s = 0; s < 150; s++) begin
            if ($urandom_range(0, 2) == 0) begin
                sw = {4'($urandom_range(0, 4)), 2'($urandom), 1'($urandom),
                      1'($urandom_range(0, 3) != 0)};
                switch = sw;
            end
            r = int'($urandom_range(0, 9));
            k = 3'b111;
            if (r < 3) k[1] = 1'b0;
            if (r == 3 || r == 4) k[2] = 1'b0;
            if (r == 5 && $urandom_range(0, 2) == 0) k[3] = 1'b0;
            key = k;
            cycles(int'($urandom_range(1, 14)));
        end
        key = 3'b111;
        cycles(30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
